// File: rtl/sr_writeback.sv
// sr_writeback: final stage of the schoolRISCV pipeline.
// Commits results, resolves branches and squashes wrong-path bundles.
module sr_writeback #(
  parameter int FLUSH_DEPTH = 2,
  parameter int INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_i,
  input  logic                 wdSrc_i,
  input  logic                 regWrite_i,
  input  logic                 branch_i,
  input  logic                 condZero_i,
  input  logic                 aluZero_i,
  input  logic [31:0]          aluResult_i,
  input  logic [4:0]           rd_i,
  input  logic [31:0]          immU_i,
  input  logic [31:0]          pcBranch_i,
  input  logic [31:0]          pcPlus4_i,
  output logic                 rfWe_o,
  output logic [4:0]           rfWa_o,
  output logic [31:0]          rfWd_o,
  output logic                 pcSrc_o,
  output logic [31:0]          pcTarget_o,
  output logic                 flush_o,
  output logic                 fwdValid_o,
  output logic [4:0]           fwdRd_o,
  output logic [31:0]          fwdData_o,
  output logic [31:0]          pcCommit_o,
  output logic [INSTRET_W-1:0] instret_o
);

  localparam int SQW = $clog2(FLUSH_DEPTH + 1);

  typedef struct packed {
    logic        wdSrc;
    logic        regWrite;
    logic        branch;
    logic        condZero;
    logic        aluZero;
    logic [31:0] aluResult;
    logic [4:0]  rd;
    logic [31:0] immU;
    logic [31:0] pcBranch;
    logic [31:0] pcPlus4;
  } wbBundle_t;

  wbBundle_t            bIn;
  wbBundle_t            bR;
  logic                 validR;
  logic [SQW-1:0]       sqCnt;
  logic [INSTRET_W-1:0] instretR;
  logic                 squashNow;

  assign bIn = '{
    wdSrc:     wdSrc_i,
    regWrite:  regWrite_i,
    branch:    branch_i,
    condZero:  condZero_i,
    aluZero:   aluZero_i,
    aluResult: aluResult_i,
    rd:        rd_i,
    immU:      immU_i,
    pcBranch:  pcBranch_i,
    pcPlus4:   pcPlus4_i
  };

  assign rfWd_o     = bR.wdSrc ? bR.immU : bR.aluResult;
  assign rfWa_o     = bR.rd;
  assign rfWe_o     = validR & bR.regWrite & (bR.rd != 5'd0);
  assign fwdValid_o = rfWe_o;
  assign fwdRd_o    = bR.rd;
  assign fwdData_o  = rfWd_o;
  assign pcSrc_o    = validR & bR.branch & (bR.aluZero == bR.condZero);
  assign pcTarget_o = bR.pcBranch;
  assign pcCommit_o = bR.pcPlus4;
  assign instret_o  = instretR;

  // sqCnt != 0 means wrong-path bundles are still arriving
  assign squashNow = pcSrc_o | (sqCnt != '0);
  assign flush_o   = squashNow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validR   <= 1'b0;
      bR       <= '0;
      sqCnt    <= '0;
      instretR <= '0;
    end else begin
      validR <= valid_i & ~squashNow;
      bR     <= bIn;
      if (pcSrc_o)
        sqCnt <= SQW'(FLUSH_DEPTH - 1);
      else if (sqCnt != '0)
        sqCnt <= sqCnt - SQW'(1);
      if (validR)
        instretR <= instretR + INSTRET_W'(1);
    end
  end

endmodule

// File: tb/tb_sr_writeback.sv
// tb_sr_writeback: table vectors plus random traffic checked
// against an edge-indexed squash model, on two parameterisations.
module tb_sr_writeback;

  typedef struct packed {
    logic        valid;
    logic        wdSrc;
    logic        regWrite;
    logic        branch;
    logic        condZero;
    logic        aluZero;
    logic [31:0] aluResult;
    logic [4:0]  rd;
    logic [31:0] immU;
    logic [31:0] pcBranch;
    logic [31:0] pcPlus4;
  } in_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        pcSrc;
    logic [31:0] target;
    logic        flush;
    logic        fv;
    logic [4:0]  frd;
    logic [31:0] fdata;
    logic [31:0] commit;
    logic [31:0] instret;
  } out_t;

  typedef struct {
    in_t         in;
    logic        we;
    logic [31:0] wd;
    logic        pcSrc;
    logic        flush;
    logic [31:0] instret;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  in_t  din = '0;
  out_t o[2];

  int nVec = 0;
  int nErr = 0;

  logic        we0, pcSrc0, flush0, fv0, we1, pcSrc1, flush1, fv1;
  logic [4:0]  wa0, frd0, wa1, frd1;
  logic [31:0] wd0, tg0, fd0, pc0, ir0, wd1, tg1, fd1, pc1;
  logic [3:0]  ir1;

  always #5 clk = ~clk;

  sr_writeback #(.FLUSH_DEPTH(2), .INSTRET_W(32)) u0 (
    .clk(clk), .rst_n(rst_n), .valid_i(din.valid),
    .wdSrc_i(din.wdSrc), .regWrite_i(din.regWrite),
    .branch_i(din.branch), .condZero_i(din.condZero),
    .aluZero_i(din.aluZero), .aluResult_i(din.aluResult),
    .rd_i(din.rd), .immU_i(din.immU), .pcBranch_i(din.pcBranch),
    .pcPlus4_i(din.pcPlus4), .rfWe_o(we0), .rfWa_o(wa0),
    .rfWd_o(wd0), .pcSrc_o(pcSrc0), .pcTarget_o(tg0),
    .flush_o(flush0), .fwdValid_o(fv0), .fwdRd_o(frd0),
    .fwdData_o(fd0), .pcCommit_o(pc0), .instret_o(ir0)
  );

  sr_writeback #(.FLUSH_DEPTH(1), .INSTRET_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .valid_i(din.valid),
    .wdSrc_i(din.wdSrc), .regWrite_i(din.regWrite),
    .branch_i(din.branch), .condZero_i(din.condZero),
    .aluZero_i(din.aluZero), .aluResult_i(din.aluResult),
    .rd_i(din.rd), .immU_i(din.immU), .pcBranch_i(din.pcBranch),
    .pcPlus4_i(din.pcPlus4), .rfWe_o(we1), .rfWa_o(wa1),
    .rfWd_o(wd1), .pcSrc_o(pcSrc1), .pcTarget_o(tg1),
    .flush_o(flush1), .fwdValid_o(fv1), .fwdRd_o(frd1),
    .fwdData_o(fd1), .pcCommit_o(pc1), .instret_o(ir1)
  );

  always_comb begin
    o[0] = '{we0, wa0, wd0, pcSrc0, tg0, flush0, fv0, frd0, fd0, pc0, ir0};
    o[1] = '{we1, wa1, wd1, pcSrc1, tg1, flush1, fv1, frd1, fd1, pc1,
             {28'd0, ir1}};
  end

  // Reference model: the bundle captured at edge e is dropped when
  // a taken branch was captured at edge t with t < e <= t+depth.
  int          depth[2] = '{2, 1};
  logic [31:0] cntMask[2] = '{32'hFFFF_FFFF, 32'h0000_000F};
  in_t         ms[2];
  int          takenEdge[2];
  logic [31:0] cnt[2];
  int          edgeN = 0;

  function automatic bit squashedAt(int k, int e);
    return (e > takenEdge[k]) && (e <= takenEdge[k] + depth[k]);
  endfunction

  function automatic bit taken(in_t b);
    return b.valid && b.branch && (b.aluZero == b.condZero);
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      ms[k] = '0;
      takenEdge[k] = -100;
      cnt[k] = 0;
    end
  endtask

  task automatic modelEdge(int k, in_t x);
    if (ms[k].valid) cnt[k] = (cnt[k] + 1) & cntMask[k];
    ms[k] = x;
    ms[k].valid = x.valid && !squashedAt(k, edgeN);
    if (taken(ms[k])) takenEdge[k] = edgeN;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkModel(int k);
    logic        eWe;
    logic [31:0] eWd;
    eWe = ms[k].valid && ms[k].regWrite && (ms[k].rd != 0);
    eWd = ms[k].wdSrc ? ms[k].immU : ms[k].aluResult;
    chk($sformatf("u%0d we", k), 32'(o[k].we), 32'(eWe));
    chk($sformatf("u%0d wa", k), 32'(o[k].wa), 32'(ms[k].rd));
    chk($sformatf("u%0d wd", k), o[k].wd, eWd);
    chk($sformatf("u%0d pcSrc", k), 32'(o[k].pcSrc), 32'(taken(ms[k])));
    chk($sformatf("u%0d target", k), o[k].target, ms[k].pcBranch);
    chk($sformatf("u%0d flush", k), 32'(o[k].flush),
        32'(squashedAt(k, edgeN + 1)));
    chk($sformatf("u%0d fwdValid", k), 32'(o[k].fv), 32'(eWe));
    chk($sformatf("u%0d fwdRd", k), 32'(o[k].frd), 32'(ms[k].rd));
    chk($sformatf("u%0d fwdData", k), o[k].fdata, eWd);
    chk($sformatf("u%0d commit", k), o[k].commit, ms[k].pcPlus4);
    chk($sformatf("u%0d instret", k), o[k].instret, cnt[k]);
  endtask

  task automatic step(in_t x);
    din = x;
    @(posedge clk);
    edgeN++;
    for (int k = 0; k < 2; k++) modelEdge(k, x);
    #1;
    for (int k = 0; k < 2; k++) checkModel(k);
  endtask

  function automatic in_t mk(logic v, logic ws, logic rw, logic br,
                             logic cz, logic az, logic [31:0] alu,
                             logic [4:0] rd, logic [31:0] imm,
                             logic [31:0] pb, logic [31:0] pc);
    return '{v, ws, rw, br, cz, az, alu, rd, imm, pb, pc};
  endfunction

  function automatic in_t add(logic [4:0] rd, logic [31:0] alu);
    return mk(1, 0, 1, 0, 0, 0, alu, rd, 32'h0, 32'h0, 32'h40);
  endfunction

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{add(5, 32'h1234), 1, 32'h1234, 0, 0, 0};
    tbl[1]  = '{mk(1, 1, 1, 0, 0, 0, 32'hFFFF_FFFF, 3, 32'hABCD_E000,
                   0, 32'h14), 1, 32'hABCD_E000, 0, 0, 1};
    tbl[2]  = '{mk(1, 1, 1, 0, 0, 0, 32'hFFFF_FFFF, 0, 32'hABCD_E000,
                   0, 32'h18), 0, 32'hABCD_E000, 0, 0, 2};
    tbl[3]  = '{mk(1, 0, 0, 1, 1, 1, 32'h0, 0, 32'h0, 32'h100, 32'h1C),
                0, 32'h0, 1, 1, 3};
    tbl[4]  = '{add(1, 32'h11), 0, 32'h11, 0, 1, 4};
    tbl[5]  = '{add(2, 32'h22), 0, 32'h22, 0, 0, 4};
    tbl[6]  = '{add(7, 32'h77), 1, 32'h77, 0, 0, 4};
    tbl[7]  = '{mk(1, 0, 0, 1, 0, 1, 32'h0, 0, 32'h0, 32'h200, 32'h2C),
                0, 32'h0, 0, 0, 5};
    tbl[8]  = '{add(9, 32'h99), 1, 32'h99, 0, 0, 6};
    tbl[9]  = '{mk(0, 0, 1, 1, 1, 1, 32'h5, 6, 32'h0, 32'h300, 0),
                0, 32'h5, 0, 0, 7};
    tbl[10] = '{mk(0, 0, 1, 1, 1, 1, 32'h5, 6, 32'h0, 32'h300, 0),
                0, 32'h5, 0, 0, 7};
    tbl[11] = '{mk(0, 0, 1, 1, 1, 1, 32'h5, 6, 32'h0, 32'h300, 0),
                0, 32'h5, 0, 0, 7};

    modelReset();
    repeat (2) @(posedge clk);
    #2;
    chk("rst we", 32'(we0), 0);
    chk("rst flush", 32'(flush0), 0);
    chk("rst instret", ir0, 0);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) checkModel(k);

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].in);
      chk($sformatf("tbl%0d we", i), 32'(we0), 32'(tbl[i].we));
      chk($sformatf("tbl%0d wd", i), wd0, tbl[i].wd);
      chk($sformatf("tbl%0d pcSrc", i), 32'(pcSrc0), 32'(tbl[i].pcSrc));
      chk($sformatf("tbl%0d flush", i), 32'(flush0), 32'(tbl[i].flush));
      chk($sformatf("tbl%0d instret", i), ir0, tbl[i].instret);
      if (i == 3) chk("beq target", tg0, 32'h100);
    end

    // asynchronous reset one cycle into a flush
    step(mk(1, 0, 0, 1, 1, 1, 0, 0, 0, 32'h500, 32'h60));
    step(add(8, 32'h88));
    chk("midflush flush", 32'(flush0), 1);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    chk("async flush", 32'(flush0), 0);
    chk("async we", 32'(we0), 0);
    chk("async instret", ir0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step(add(4, 32'h44));
    chk("post-rst we", 32'(we0), 1);
    chk("post-rst wd", wd0, 32'h44);

    for (int i = 0; i < 400; i++) begin
      in_t r;
      r.valid     = ($urandom_range(3) != 0);
      r.wdSrc     = 1'($urandom_range(1));
      r.regWrite  = 1'($urandom_range(1));
      r.branch    = ($urandom_range(3) == 0);
      r.condZero  = 1'($urandom_range(1));
      r.aluZero   = 1'($urandom_range(1));
      r.aluResult = $urandom;
      r.rd        = 5'($urandom_range(31));
      r.immU      = $urandom & 32'hFFFF_F000;
      r.pcBranch  = $urandom & 32'hFFFF_FFFC;
      r.pcPlus4   = $urandom & 32'hFFFF_FFFC;
      step(r);
    end

    // 4-bit counter wrap on the depth-1 instance
    rst_n = 1'b0;
    #1;
    modelReset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) step(add(10, 32'(i)));
    chk("wrap u1 instret", 32'(ir1), 0);
    chk("wrap u0 instret", ir0, 16);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
